// File: rtl/onecold_encoder.sv
// onecold_encoder: synchronizes and debounces four active-low request lines,
// encodes the asserted line to a 2-bit index and offers it on valid/ready.
// A new code is accepted only after a debounced full release.
module onecold_encoder #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] y_n,
    output logic [1:0] code,
    output logic       multi_err,
    output logic       valid,
    input  logic       ready,
    output logic       idle
);

    localparam int unsigned LINES = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ZC_W  = 3;
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [LINES-1:0] NONE_LOW = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEB,
        S_HOLD,
        S_REL
    } state_t;

    state_t            state, state_nxt;
    logic [LINES-1:0]  y_s1, y_s;
    logic [LINES-1:0]  cand, cand_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [1:0]        code_nxt, enc_code;
    logic              multi_nxt, enc_multi;
    logic              valid_nxt, idle_nxt;
    logic [ZC_W-1:0]   zeros;

    // Two-flop synchronizer; idles at "no line asserted"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s1 <= NONE_LOW;
            y_s  <= NONE_LOW;
        end else begin
            y_s1 <= y_n;
            y_s  <= y_s1;
        end
    end

    // Encode candidate: highest-numbered low line wins, flag multiple lows
    always_comb begin
        zeros = '0;
        for (int i = 0; i < LINES; i++) begin
            zeros = zeros + {2'b00, !cand[i]};
        end
        enc_multi = (zeros > ZC_W'(1));
        if (!cand[3])      enc_code = 2'd3;
        else if (!cand[2]) enc_code = 2'd2;
        else if (!cand[1]) enc_code = 2'd1;
        else               enc_code = 2'd0;
    end

    // Saturating debounce counter increment
    always_comb begin
        cnt_inc = (cnt >= DEB_MAX) ? cnt : cnt + CNT_W'(1);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cand      <= NONE_LOW;
            cnt       <= '0;
            code      <= 2'b00;
            multi_err <= 1'b0;
            valid     <= 1'b0;
            idle      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            code      <= code_nxt;
            multi_err <= multi_nxt;
            valid     <= valid_nxt;
            idle      <= idle_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        code_nxt  = code;
        multi_nxt = multi_err;
        valid_nxt = valid;

        case (state)
            S_IDLE: begin
                if (y_s != NONE_LOW) begin
                    cand_nxt  = y_s;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = S_DEB;
                end
            end
            S_DEB: begin
                if (y_s == cand) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == DEB_MAX) begin
                        code_nxt  = enc_code;
                        multi_nxt = enc_multi;
                        valid_nxt = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end else if (y_s == NONE_LOW) begin
                    // glitch shorter than the debounce window: drop it
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cand_nxt = y_s;
                    cnt_nxt  = CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (valid && ready) begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_REL;
                end
            end
            S_REL: begin
                if (y_s == NONE_LOW) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == DEB_MAX) begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                valid_nxt = 1'b0;
            end
        endcase

        idle_nxt = (state_nxt == S_IDLE);
    end

endmodule

// File: tb/tb_onecold_encoder.sv
// Bench for onecold_encoder: scoreboard of expected codes checked on accept,
// plus per-scenario timing and level checks.
module tb_onecold_encoder;

    localparam int unsigned DEBOUNCE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] y_n;
    logic [1:0] code;
    logic       multi_err;
    logic       valid;
    logic       ready;
    logic       idle;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [1:0] code;
        logic       multi;
    } exp_t;

    exp_t exp_q[$];

    onecold_encoder #(.DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .y_n       (y_n),
        .code      (code),
        .multi_err (multi_err),
        .valid     (valid),
        .ready     (ready),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted code must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL accept_unexpected: got code=%0d multi=%0d, required no output", code, multi_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({code, multi_err} !== {e.code, e.multi})
                    $display("FAIL accept_value: got code=%0d multi=%0d, required code=%0d multi=%0d",
                             code, multi_err, e.code, e.multi);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && valid !== 1'b1; i++) tick();
        n_checks++;
        if (valid !== 1'b1) $display("FAIL %s_timeout: valid=%b, required 1 within 40 cycles", name, valid);
        else n_pass++;
    endtask

    task automatic release_lines(input int cycles);
        y_n = 4'b1111;
        repeat (cycles) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        y_n   = 4'b1110;
        ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({valid, code, multi_err, idle} !== 5'b0_00_0_1)
            $display("FAIL reset_outputs: got valid=%b code=%0d multi=%b idle=%b, required 0 0 0 1",
                     valid, code, multi_err, idle);
        else n_pass++;
        exp_q.push_back('{code: 2'd0, multi: 1'b0});
        rst_n = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            n_checks++;
            if (valid !== (e == 5))
                $display("FAIL reset_latency_edge%0d: valid=%b, required %b", e, valid, (e == 5));
            else n_pass++;
        end
        release_lines(12);
        n_checks++;
        if (idle !== 1'b1) $display("FAIL reset_release_idle: idle=%b, required 1", idle);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [3:0] pats [4];
        pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
        ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            int vcnt = 0;
            exp_q.push_back('{code: 2'(p), multi: 1'b0});
            y_n = pats[p];
            for (int i = 0; i < 10; i++) begin
                tick();
                if (valid === 1'b1) vcnt++;
            end
            n_checks++;
            if (vcnt != 1) $display("FAIL sweep_width_%0d: valid cycles=%0d, required 1", p, vcnt);
            else n_pass++;
            release_lines(10);
        end
        n_checks++;
        if (idle !== 1'b1) $display("FAIL sweep_idle: idle=%b, required 1", idle);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int vcnt = 0;
        int low  = 0;
        ready = 1'b1;
        y_n   = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid === 1'b1) vcnt++;
            if (idle !== 1'b1) low++;
        end
        y_n = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid === 1'b1) vcnt++;
            if (idle !== 1'b1) low++;
        end
        n_checks++;
        if (vcnt != 0) $display("FAIL glitch_valid: valid cycles=%0d, required 0", vcnt);
        else n_pass++;
        n_checks++;
        if (low < 1 || low > DEBOUNCE) $display("FAIL glitch_idle_low: idle-low cycles=%0d, required 1..%0d", low, DEBOUNCE);
        else n_pass++;
        n_checks++;
        if (idle !== 1'b1) $display("FAIL glitch_idle_end: idle=%b, required 1", idle);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad  = 0;
        int vcnt = 0;
        ready = 1'b0;
        exp_q.push_back('{code: 2'd2, multi: 1'b0});
        y_n = 4'b1011;
        wait_valid("bp");
        n_checks++;
        if (code !== 2'd2) $display("FAIL bp_code: code=%0d, required 2", code);
        else n_pass++;
        y_n = 4'b0111;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid !== 1'b1 || code !== 2'd2 || multi_err !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: %0d cycles changed, required 0 (code=%0d valid=%b)", bad, code, valid);
        else n_pass++;
        ready = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL bp_accept: valid=%b after accept, required 0", valid);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt != 0) $display("FAIL bp_held_line: valid cycles=%0d while line held, required 0", vcnt);
        else n_pass++;
        y_n = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt != 0 || idle !== 1'b1)
            $display("FAIL bp_release: valid cycles=%0d idle=%b, required 0 and 1", vcnt, idle);
        else n_pass++;
    endtask

    task automatic test_multi();
        int vcnt = 0;
        ready = 1'b1;
        exp_q.push_back('{code: 2'd2, multi: 1'b1});
        y_n = 4'b1010;
        wait_valid("multi");
        n_checks++;
        if ({code, multi_err} !== 3'b10_1) $display("FAIL multi_value: code=%0d multi=%b, required 2 1", code, multi_err);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt != 0) $display("FAIL multi_width: extra valid cycles=%0d, required 0", vcnt);
        else n_pass++;
        release_lines(12);
    endtask

    task automatic test_async_reset();
        int vcnt = 0;
        ready = 1'b0;
        exp_q.push_back('{code: 2'd0, multi: 1'b0});
        y_n = 4'b1110;
        wait_valid("arst");
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || idle !== 1'b1)
            $display("FAIL arst_immediate: valid=%b idle=%b, required 0 1", valid, idle);
        else n_pass++;
        exp_q.delete();
        y_n   = 4'b1111;
        ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt != 0 || idle !== 1'b1)
            $display("FAIL arst_stale: valid cycles=%0d idle=%b, required 0 1", vcnt, idle);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        y_n   = 4'b1111;
        ready = 1'b0;
        test_reset();
        test_sweep();
        test_glitch();
        test_backpressure();
        test_multi();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d codes never delivered, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onecold_encoder.md
# onecold_encoder

Sequential 4-to-2 encoder for active-low one-cold line groups, the receive-side counterpart of the team's 2-to-4 active-low decoder. It synchronizes and debounces four asynchronous active-low request lines, encodes the asserted line to a 2-bit code and presents it on a valid/ready handshake. After each accepted code it waits for a debounced full release before accepting a new request. It sits between external one-cold sources (keys, select strobes) and the control logic that consumes the code.

## Interface

- DEBOUNCE, 4: consecutive synchronized samples needed to accept a press or a release; legal range 2..255.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- y_n  input  4  asynchronous active-low request lines; 4'b1111 means none asserted.
- code  output  2  encoded line index (0..3); meaningful while valid=1.
- multi_err  output  1  more than one line was low in the accepted pattern; qualified by valid.
- valid  output  1  code and multi_err are available.
- ready  input  1  consumer accepts code on any cycle where valid=1 and ready=1.
- idle  output  1  high only in the IDLE state.

## Operation

- Synchronizer: two flops on y_n give y_s; both flops reset to 4'b1111. Only y_s is used downstream.
- Internal registers:
  - cand[3:0] holds the candidate pattern.
  - cnt is 8 bits and saturates at DEBOUNCE.
- IDLE:
  - If y_s != 4'b1111: cand <= y_s, cnt <= 1, go to DEB.
- DEB:
  - If y_s == cand: cnt++. When the increment reaches DEBOUNCE, latch outputs, set valid=1 and go to HOLD.
  - If y_s != cand and y_s == 4'b1111: go to IDLE. The glitch is discarded with no output.
  - If y_s != cand and y_s != 4'b1111: cand <= y_s, cnt <= 1, stay in DEB.
- Encoding at the accept edge:
  - code = index of the highest-numbered zero bit of cand.
  - multi_err = 1 if cand has more than one zero bit.
  - Examples: 1110 gives code 0; 1101 gives 1; 1011 gives 2; 0111 gives 3; 1010 gives code 2 with multi_err=1.
- HOLD:
  - valid stays 1, and code and multi_err stay frozen, regardless of y_s.
  - On an edge with valid=1 and ready=1: valid <= 0, cnt <= 0, go to REL.
  - ready while valid=0 has no effect.
- REL:
  - If y_s == 4'b1111: cnt++. When cnt reaches DEBOUNCE, go to IDLE.
  - Any y_s != 4'b1111 resets cnt to 0.
  - A held or re-pressed line never produces a second code until a full debounced release.
- Reset: asserting rst_n low at any time, including mid-DEB or mid-HOLD, immediately forces the state to IDLE. A pending code is dropped, not delivered after reset.

## Timing

- Reset values:
  - valid = 0, code = 2'b00, multi_err = 0, idle = 1.
  - state = IDLE, cnt = 0, cand = 4'b1111, synchronizer flops = 4'b1111.
- All outputs are registered; none depends combinationally on y_n or ready.
- Press latency: y_n stable before edge 0 gives y_s updated at edge 1, DEB entered at edge 2, and valid high after edge DEBOUNCE+1 (edge 5 for the default).
- A pattern held for fewer than DEBOUNCE consecutive y_s samples never asserts valid.
- Handshake:
  - Accept occurs at the first edge k with valid=1 and ready=1; valid is low after edge k.
  - If ready is held high at entry to HOLD, valid is high for exactly one cycle.
- Release latency: with y_n already 4'b1111, idle rises after edge k+DEBOUNCE. Each low sample in REL restarts the count.
- Simultaneous events: a pattern change on the same edge that would complete the count restarts DEB with the new pattern; the comparison uses the y_s value at that edge.

## Test plan

- Reset: hold rst_n=0 with y_n=4'b1110 → valid=0, code=0, idle=1. Release rst_n, y_n still 1110, ready=1 → valid pulses one cycle at edge 5 (relative to the first post-reset edge) with code=0.
- Sweep, DEBOUNCE=4, ready=1: drive y_n 1110, 1101, 1011, 0111, each held 10 cycles with 10 cycles of 1111 between → codes 0, 1, 2, 3, each with multi_err=0, each valid one cycle wide.
- Glitch rejection: y_n=1101 for 3 cycles, then 1111 → valid never asserts, and idle returns to 1 without dropping below 0 for more than DEB.
- Backpressure: ready=0, press 1011 → valid high with code=2. Hold ready=0 for 20 cycles while y_n changes to 0111 → code stays 2. Raise ready → one accept, then no new code until y_n=1111 for 4 cycles.
- Multi-press: y_n=1010 stable → code=2, multi_err=1.
- Async reset mid-operation: assert rst_n=0 asynchronously (between edges) during HOLD → valid drops immediately, not at the next edge, and idle=1. After rst_n returns high, no stale code is delivered.
